// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the memory stage.
// Size encoding follows the execute-stage control bundle.
package mem_pkg;

  typedef enum logic [1:0] {
    MSZ_BYTE = 2'd0,
    MSZ_HALF = 2'd1,
    MSZ_WORD = 2'd2
  } msize_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_DRAIN
  } mstate_e;

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic m;
    if (sz == MSZ_BYTE)
      m = 1'b0;
    else if (sz == MSZ_HALF)
      m = off[0];
    else
      m = (off != 2'b00);
    return m;
  endfunction

  function automatic logic [3:0] strobe_of(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic [3:0] s;
    case (sz)
      MSZ_BYTE: s = 4'b0001 << off;
      MSZ_HALF: s = 4'b0011 << off;
      default:  s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] replicate(
    input logic [31:0] wd,
    input logic [1:0]  sz
  );
    logic [31:0] r;
    case (sz)
      MSZ_BYTE: r = {4{wd[7:0]}};
      MSZ_HALF: r = {2{wd[15:0]}};
      default:  r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend(
    input logic [31:0] lane,
    input logic [1:0]  sz,
    input logic        sx
  );
    logic [31:0] e;
    case (sz)
      MSZ_BYTE: e = {{24{sx & lane[7]}}, lane[7:0]};
      MSZ_HALF: e = {{16{sx & lane[15]}}, lane[15:0]};
      default:  e = lane;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane strobe / store replication and load extraction.
// Purely combinational; shared with the cache model.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strobe,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] lane;

  assign lane       = rdata >> {offset, 3'b000};
  assign strobe     = strobe_of(size, offset);
  assign wdata_lane = replicate(wdata, size);
  assign rdata_ext  = extend(lane, size, sign_ext);

endmodule

// File: rtl/memory_access.sv
// Memory stage: alignment check, dcache handshake, load
// extraction and write-back presentation.
module memory_access
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [1:0]  in_size,
  input  logic        in_sign_ext,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_writereg,
  input  logic        in_regwrite,
  input  logic        advance,
  input  logic        flush,
  output logic        dreq_valid,
  output logic        dreq_write,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_wdata,
  input  logic        daddr_ok,
  input  logic        ddata_ok,
  input  logic [31:0] drdata,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic [4:0]  out_writereg,
  output logic        out_regwrite,
  output logic        out_adel,
  output logic        out_ades,
  output logic [31:0] out_badvaddr
);

  mstate_e     state;
  logic [31:0] data_q;
  logic        mem_op;
  logic        mis;
  logic        go;
  logic        req;
  logic        stall_i;
  logic [3:0]  strb;
  logic [31:0] wlane;
  logic [31:0] load_ext;

  assign mem_op = in_valid & (in_is_load | in_is_store);
  assign mis    = misaligned(in_size, in_addr[1:0]);
  assign go     = mem_op & ~mis & ~flush;
  assign req    = go & (state == S_IDLE ||
                        state == S_ADDR);

  mem_lane_align u_align (
    .size       (in_size),
    .sign_ext   (in_sign_ext),
    .offset     (in_addr[1:0]),
    .wdata      (in_wdata),
    .rdata      (drdata),
    .strobe     (strb),
    .wdata_lane (wlane),
    .rdata_ext  (load_ext)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      data_q <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_ADDR: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (daddr_ok & ddata_ok) begin
            data_q <= load_ext;
            state  <= S_DONE;
          end else if (daddr_ok) begin
            state <= S_DATA;
          end else begin
            state <= S_ADDR;
          end
        end
        S_DATA: begin
          if (flush) begin
            state <= ddata_ok ? S_IDLE : S_DRAIN;
          end else if (ddata_ok) begin
            data_q <= load_ext;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (advance | flush)
            state <= S_IDLE;
        end
        S_DRAIN: begin
          if (ddata_ok)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held.
  assign stall_i = (state == S_DRAIN) |
                   (go & (state != S_DONE));
  assign stall   = resetn & stall_i;

  assign dreq_valid  = resetn & req;
  assign dreq_write  = dreq_valid & in_is_store;
  assign dreq_addr   = dreq_valid ? in_addr : '0;
  assign dreq_size   = dreq_valid ? in_size : '0;
  assign dreq_strobe = dreq_valid ? strb : '0;
  assign dreq_wdata  = dreq_valid ? wlane : '0;

  assign out_valid = resetn & in_valid &
                     ~flush & ~stall_i;
  assign out_adel  = out_valid & in_is_load & mis;
  assign out_ades  = out_valid & in_is_store & mis;

  assign out_badvaddr = (out_adel | out_ades) ?
                        in_addr : '0;

  assign out_result =
    !resetn ? '0 :
    (in_is_load && state == S_DONE) ? data_q :
    in_addr;

  assign out_writereg = resetn ? in_writereg : '0;
  assign out_regwrite = out_valid & in_regwrite &
                        ~in_is_store &
                        ~(in_is_load & mis);

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: vector table
// with an inline cache model plus flush/reset sequences.
module tb_memory_access;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_is_load, in_is_store;
  logic [1:0]  in_size;
  logic        in_sign_ext;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_writereg;
  logic        in_regwrite, advance, flush;
  logic        dreq_valid, dreq_write;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_wdata;
  logic        daddr_ok, ddata_ok;
  logic [31:0] drdata;
  logic        stall, out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_writereg;
  logic        out_regwrite, out_adel, out_ades;
  logic [31:0] out_badvaddr;

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_size(in_size),
    .in_sign_ext(in_sign_ext), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_writereg(in_writereg),
    .in_regwrite(in_regwrite), .advance(advance),
    .flush(flush), .dreq_valid(dreq_valid),
    .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_wdata(dreq_wdata), .daddr_ok(daddr_ok),
    .ddata_ok(ddata_ok), .drdata(drdata),
    .stall(stall), .out_valid(out_valid),
    .out_result(out_result),
    .out_writereg(out_writereg),
    .out_regwrite(out_regwrite),
    .out_adel(out_adel), .out_ades(out_ades),
    .out_badvaddr(out_badvaddr)
  );

  typedef struct {
    bit          ld;
    bit          st;
    logic [1:0]  sz;
    bit          sx;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          aw;
    int          dw;
    logic [3:0]  strb;
    logic [31:0] ewd;
    logic [31:0] res;
    bit          adel;
    bit          ades;
    bit          rw;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
    flush       = 1'b0;
    daddr_ok    = 1'b0;
    ddata_ok    = 1'b0;
    drdata      = '0;
  endtask

  task automatic drive_lw(input logic [31:0] a);
    in_valid    = 1'b1;
    in_is_load  = 1'b1;
    in_is_store = 1'b0;
    in_size     = MSZ_WORD;
    in_sign_ext = 1'b0;
    in_addr     = a;
    in_wdata    = '0;
    in_regwrite = 1'b1;
    in_writereg = 5'd9;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  cyc, a, d, ph, reqs, stl;
    bit  drift, done, mem;
    logic [31:0] e;
    logic [4:0]  wr;
    mem = (v.ld | v.st) & ~(v.adel | v.ades);
    wr  = 5'(idx + 1);
    @(negedge clk);
    in_valid    = 1'b1;
    in_is_load  = v.ld;
    in_is_store = v.st;
    in_size     = v.sz;
    in_sign_ext = v.sx;
    in_addr     = v.addr;
    in_wdata    = v.wd;
    in_regwrite = 1'b1;
    in_writereg = wr;
    exp_q.push_back(v.res);
    a = 0; d = 0; ph = 0; reqs = 0; stl = 0;
    drift = 1'b0; done = 1'b0; cyc = 0;
    while (!done && cyc < 40) begin
      #1;
      if (out_valid) begin
        done = 1'b1;
      end else begin
        if (stall) stl++;
        if (dreq_valid && ph != 0) reqs++;
        if (ph == 0 && dreq_valid) begin
          if (dreq_addr !== v.addr ||
              dreq_strobe !== v.strb ||
              dreq_wdata !== v.ewd ||
              dreq_write !== v.st ||
              dreq_size !== v.sz)
            drift = 1'b1;
          if (a == v.aw) begin
            daddr_ok = 1'b1;
            reqs++;
            if (v.dw == 0) begin
              ddata_ok = 1'b1;
              drdata   = v.rd;
              ph = 2;
            end else begin
              ph = 1;
              d  = 0;
            end
          end else begin
            a++;
          end
        end else if (ph == 1) begin
          d++;
          if (d == v.dw) begin
            ddata_ok = 1'b1;
            drdata   = v.rd;
            ph = 2;
          end
        end
        @(negedge clk);
        daddr_ok = 1'b0;
        ddata_ok = 1'b0;
        drdata   = '0;
        cyc++;
      end
    end
    if (!done) begin
      check($sformatf("v%0d timeout", idx), 1, 0);
      void'(exp_q.pop_front());
      resetn = 1'b0;
      #1 resetn = 1'b1;
    end else begin
      e = exp_q.pop_front();
      check($sformatf("v%0d result", idx), out_result, e);
      check($sformatf("v%0d stall_cycles", idx), stl,
            mem ? v.aw + v.dw + 1 : 0);
      check($sformatf("v%0d requests", idx), reqs,
            mem ? 1 : 0);
      check($sformatf("v%0d req_stable", idx),
            {31'd0, drift}, 0);
      check($sformatf("v%0d regwrite", idx),
            {31'd0, out_regwrite}, {31'd0, v.rw});
      check($sformatf("v%0d adel", idx),
            {31'd0, out_adel}, {31'd0, v.adel});
      check($sformatf("v%0d ades", idx),
            {31'd0, out_ades}, {31'd0, v.ades});
      check($sformatf("v%0d badvaddr", idx), out_badvaddr,
            (v.adel | v.ades) ? v.addr : 32'h0);
      check($sformatf("v%0d writereg", idx),
            {27'd0, out_writereg}, {27'd0, wr});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, MSZ_WORD, 1'b0, 32'h1000,
      32'h0, 32'hDEADBEEF, 0, 1, 4'hF, 32'h0,
      32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, MSZ_BYTE, 1'b1, 32'h1003,
      32'h0, 32'h80FF0000, 0, 0, 4'h8, 32'h0,
      32'hFFFFFF80, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, MSZ_BYTE, 1'b0, 32'h1003,
      32'h0, 32'h80FF0000, 1, 0, 4'h8, 32'h0,
      32'h00000080, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, MSZ_HALF, 1'b0, 32'h1002,
      32'h1234ABCD, 32'h0, 0, 1, 4'hC, 32'hABCDABCD,
      32'h00001002, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, MSZ_WORD, 1'b0, 32'h1001,
      32'h0, 32'h0, 0, 0, 4'h0, 32'h0,
      32'h00001001, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, MSZ_WORD, 1'b0, 32'h2000,
      32'h0, 32'h01234567, 3, 0, 4'hF, 32'h0,
      32'h01234567, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, MSZ_WORD, 1'b0, 32'h2004,
      32'hCAFEF00D, 32'h0, 3, 2, 4'hF, 32'hCAFEF00D,
      32'h00002004, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, MSZ_HALF, 1'b1, 32'h3002,
      32'h0, 32'h80017FFF, 1, 1, 4'hC, 32'h0,
      32'hFFFF8001, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, MSZ_HALF, 1'b0, 32'h3000,
      32'h0, 32'h8001F234, 0, 2, 4'h3, 32'h0,
      32'h0000F234, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, MSZ_BYTE, 1'b0, 32'h4001,
      32'h000000A5, 32'h0, 2, 0, 4'h2, 32'hA5A5A5A5,
      32'h00004001, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, MSZ_HALF, 1'b0, 32'h4001,
      32'h0, 32'h0, 0, 0, 4'h0, 32'h0,
      32'h00004001, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, MSZ_WORD, 1'b0, 32'h12345678,
      32'h0, 32'h0, 0, 0, 4'h0, 32'h0,
      32'h12345678, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, MSZ_BYTE, 1'b0, 32'h5001,
      32'h0, 32'h0000C300, 0, 0, 4'h2, 32'h0,
      32'h000000C3, 1'b0, 1'b0, 1'b1};

    resetn  = 1'b0;
    advance = 1'b1;
    idle_inputs();
    drive_lw(32'h1000);
    #1;
    check("rst dreq_valid", {31'd0, dreq_valid}, 0);
    check("rst stall", {31'd0, stall}, 0);
    check("rst out_valid", {31'd0, out_valid}, 0);
    check("rst out_result", out_result, 0);
    check("rst dreq_addr", dreq_addr, 0);
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++)
      run_vec(i, vecs[i]);

    // Flush while waiting for data, then a new load.
    @(negedge clk);
    drive_lw(32'h6000);
    daddr_ok = 1'b1;
    #1 check("fl issue", {31'd0, dreq_valid}, 1);
    @(negedge clk);
    daddr_ok = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive_lw(32'h7000);
    #1;
    check("fl drain stall0", {31'd0, stall}, 1);
    check("fl drain noreq0", {31'd0, dreq_valid}, 0);
    @(negedge clk);
    ddata_ok = 1'b1;
    drdata   = 32'hBAD0BAD0;
    #1;
    check("fl drain stall1", {31'd0, stall}, 1);
    check("fl drain noreq1", {31'd0, dreq_valid}, 0);
    @(negedge clk);
    ddata_ok = 1'b0;
    drdata   = '0;
    #1;
    check("fl new req", {31'd0, dreq_valid}, 1);
    check("fl new addr", dreq_addr, 32'h7000);
    check("fl new stall", {31'd0, stall}, 1);
    exp_q.push_back(32'h11112222);
    daddr_ok = 1'b1;
    ddata_ok = 1'b1;
    drdata   = 32'h11112222;
    @(negedge clk);
    daddr_ok = 1'b0;
    ddata_ok = 1'b0;
    drdata   = '0;
    #1;
    check("fl done valid", {31'd0, out_valid}, 1);
    check("fl done result", out_result,
          exp_q.pop_front());
    @(negedge clk);
    idle_inputs();

    // Reset while a response is outstanding.
    @(negedge clk);
    drive_lw(32'h8000);
    daddr_ok = 1'b1;
    @(negedge clk);
    daddr_ok = 1'b0;
    #1 check("mr in data", {31'd0, dreq_valid}, 0);
    resetn = 1'b0;
    #1 check("mr rst stall", {31'd0, stall}, 0);
    #1 resetn = 1'b1;
    #1;
    check("mr reissue", {31'd0, dreq_valid}, 1);
    check("mr stall", {31'd0, stall}, 1);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1 check("end stall", {31'd0, stall}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
